// File: rtl/keychain_pkg.sv
// Shared types and frame geometry for the keychain UART front end and expmod datapath.
package keychain_pkg;

  localparam int MSG_WIDTH   = 16;
  localparam int KEY_WIDTH   = 32;
  localparam int FRAME_BYTES = 10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 receiver: centre-samples one byte, LSB first, then flags good/bad stop bit.
// state | meaning
// IDLE  | line high, waiting for a falling edge
// START | half-bit wait, start bit re-checked to reject glitches
// DATA  | eight data bits sampled at bit centres
// STOP  | stop bit sampled at its centre, back to IDLE on that edge
module uart_rx_byte
  import keychain_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rx_in,
  output logic [7:0]     byte_out,
  output logic           byte_valid_out,
  output logic           stop_err_out,
  output uart_rx_state_t state_out
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  uart_rx_state_t state;
  logic [CW-1:0]  clk_cnt;
  logic [2:0]     bit_cnt;
  logic           bit_tick;
  logic           half_tick;

  assign bit_tick  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign half_tick = (clk_cnt == CW'(HALF - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      byte_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_in) state <= START;
        end
        START: begin
          if (half_tick) begin
            clk_cnt <= '0;
            state   <= rx_in ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            clk_cnt  <= '0;
            byte_out <= {rx_in, byte_out[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes fire on the stop-sample edge so the parent can commit the byte on that same edge.
  assign byte_valid_out = (state == STOP) && bit_tick && rx_in;
  assign stop_err_out   = (state == STOP) && bit_tick && !rx_in;
  assign state_out      = state;

endmodule

// File: rtl/uart_frame_receiver.sv
// Packs FRAME_BYTES UART bytes into one word; drops partial frames on framing error or idle timeout.
module uart_frame_receiver #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int FRAME_BYTES    = keychain_pkg::FRAME_BYTES,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rx_in,
  output logic [8*FRAME_BYTES-1:0] data_out,
  output logic                     valid_out,
  output logic                     busy_out,
  output logic                     framing_err_out
);

  import keychain_pkg::*;

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW           = $clog2(FRAME_BYTES);
  localparam int TW           = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]                     rx_byte;
  logic                           byte_valid;
  logic                           stop_err;
  uart_rx_state_t                 rx_state;
  logic [BW-1:0]                  byte_cnt;
  logic [TW-1:0]                  tmo_cnt;
  logic [8*(FRAME_BYTES-1)-1:0]   frame_buf;
  logic                           rx_idle;
  logic                           start_det;
  logic                           last_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rx_in          (rx_in),
    .byte_out       (rx_byte),
    .byte_valid_out (byte_valid),
    .stop_err_out   (stop_err),
    .state_out      (rx_state)
  );

  assign rx_idle   = (rx_state == IDLE);
  assign start_det = rx_idle && !rx_in;
  assign last_byte = (byte_cnt == BW'(FRAME_BYTES - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      byte_cnt        <= '0;
      tmo_cnt         <= '0;
      frame_buf       <= '0;
      data_out        <= '0;
      valid_out       <= 1'b0;
      framing_err_out <= 1'b0;
    end else begin
      valid_out       <= 1'b0;
      framing_err_out <= 1'b0;

      // The final byte goes straight to data_out, so the buffer only holds the first N-1.
      if (byte_valid) begin
        if (last_byte) begin
          data_out  <= {rx_byte, frame_buf};
          valid_out <= 1'b1;
          byte_cnt  <= '0;
        end else begin
          frame_buf[8*int'(byte_cnt) +: 8] <= rx_byte;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (stop_err) begin
        framing_err_out <= 1'b1;
        byte_cnt        <= '0;
      end

      // A start bit wins over an expiry on the same edge; byte_valid/stop_err never coincide with idle.
      if (start_det || !rx_idle || byte_cnt == '0) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_cnt  <= '0;
        byte_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign busy_out = !rx_idle || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver at a scaled baud (50 clocks per bit, 2000-cycle timeout).
`timescale 1ns/1ps
module tb_uart_frame_receiver;

  localparam int CPB  = 50;
  localparam int HALF = CPB / 2;
  localparam int TMO  = 2000;
  localparam int FB   = 10;

  logic            clk_100mhz = 1'b0;
  logic            rst = 1'b1;
  logic            rx = 1'b1;
  logic [8*FB-1:0] data_out;
  logic            valid_out;
  logic            busy_out;
  logic            framing_err_out;

  always #5 clk_100mhz = ~clk_100mhz;

  uart_frame_receiver #(
    .CLK_HZ(5_000_000), .BAUD(100_000), .FRAME_BYTES(FB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in          (clk_100mhz),
    .rst_in          (rst),
    .rx_in           (rx),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .busy_out        (busy_out),
    .framing_err_out (framing_err_out)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int wide_valid = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic [8*FB-1:0] got_q[$];
  logic [8*FB-1:0] exp_q[$];
  logic [7:0]      model_bytes[$];

  always @(posedge clk_100mhz) cyc++;

  always @(negedge clk_100mhz) begin
    if (valid_out) begin
      if (prev_valid) wide_valid++;
      else got_q.push_back(data_out);
      last_valid_cyc = cyc;
    end
    if (framing_err_out) ferr_cnt++;
    prev_valid = valid_out;
  end

  // Reference: a good byte joins the pending list, a full list becomes a frame (byte k at bits 8k+),
  // a bad stop bit empties the list.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [8*FB-1:0] f;
    if (!stop_ok) begin
      model_bytes.delete();
      return;
    end
    model_bytes.push_back(b);
    if (model_bytes.size() == FB) begin
      f = '0;
      foreach (model_bytes[k]) f = f | ((8*FB)'(model_bytes[k]) << (8*k));
      exp_q.push_back(f);
      model_bytes.delete();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input int per);
    rx = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(per);
    end
    rx = stop_bit;
    tick(per);
    rx = 1'b1;
    model_byte(b, stop_bit);
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    ferr_cnt   = 0;
    wide_valid = 0;
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if (data_out !== '0 || valid_out !== 1'b0 || busy_out !== 1'b0 || framing_err_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: data=%h valid=%b busy=%b ferr=%b expected all 0",
               data_out, valid_out, busy_out, framing_err_out);
    end
    rst = 1'b0;
    tick(3);
    checks++;
    if (data_out !== '0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: data=%h busy=%b expected 0/0", data_out, busy_out);
    end
  endtask

  task automatic test_basic_frame();
    int c;
    clear_obs();
    for (int k = 0; k < FB; k++) begin
      if (k == FB - 1) c = cyc;
      send_byte(8'(k + 1), 1'b1, CPB);
      if (k == 2) begin
        checks++;
        if (busy_out !== 1'b1) begin
          errors++;
          $display("FAIL basic_busy_partial: busy=%b expected 1", busy_out);
        end
      end
      tick(CPB);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 80'h0A090807060504030201) begin
      errors++;
      $display("FAIL basic_frame: count=%0d data=%h expected 1 frame 0a090807060504030201",
               got_q.size(), data_out);
    end
    checks++;
    if (exp_q.size() != 1 || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL basic_model: got count=%0d expected count=%0d", got_q.size(), exp_q.size());
    end
    checks++;
    if (last_valid_cyc != c + 1 + HALF + 9 * CPB) begin
      errors++;
      $display("FAIL basic_latency: valid at cycle %0d expected %0d", last_valid_cyc, c + 1 + HALF + 9 * CPB);
    end
    checks++;
    if (wide_valid != 0 || ferr_cnt != 0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_side: wide=%0d ferr=%0d busy=%b expected 0/0/0", wide_valid, ferr_cnt, busy_out);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    rx = 1'b0;
    tick(HALF / 4);
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy: busy=%b expected 1 during start check", busy_out);
    end
    tick(HALF / 4);
    rx = 1'b1;
    tick(2 * CPB);
    checks++;
    if (got_q.size() != 0 || ferr_cnt != 0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ignored: frames=%0d ferr=%0d busy=%b expected 0/0/0", got_q.size(), ferr_cnt, busy_out);
    end
  endtask

  task automatic test_framing_error();
    logic [8*FB-1:0] held;
    held = data_out;
    clear_obs();
    for (int k = 0; k < 5; k++) begin
      send_byte(8'($urandom), k != 4, CPB);
      tick(CPB + $urandom_range(0, CPB));
    end
    checks++;
    if (ferr_cnt != 1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL ferr_pulse: ferr=%0d frames=%0d expected 1/0", ferr_cnt, got_q.size());
    end
    checks++;
    if (data_out !== held || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL ferr_hold: data=%h busy=%b expected %h/0", data_out, busy_out, held);
    end
    for (int k = 0; k < FB; k++) begin
      send_byte(8'($urandom), 1'b1, CPB);
      tick($urandom_range(0, CPB));
    end
    tick(5);
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL ferr_recover: frames=%0d data=%h expected 1 frame %h",
               got_q.size(), data_out, exp_q.size() > 0 ? exp_q[0] : '0);
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    for (int k = 0; k < 5; k++) begin
      send_byte(8'($urandom), 1'b1, CPB);
      tick($urandom_range(1, CPB));
    end
    tick(TMO - 200);
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL tmo_not_yet: busy=%b expected 1 before timeout", busy_out);
    end
    tick(300);
    model_bytes.delete();
    checks++;
    if (busy_out !== 1'b0 || ferr_cnt != 0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL tmo_drop: busy=%b ferr=%0d frames=%0d expected 0/0/0", busy_out, ferr_cnt, got_q.size());
    end
    for (int k = 0; k < FB; k++) begin
      send_byte(8'hA0 + 8'(k), 1'b1, CPB);
      tick(CPB);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 80'hA9A8A7A6A5A4A3A2A1A0 || exp_q.size() != 1 || exp_q[0] !== got_q[0]) begin
      errors++;
      $display("FAIL tmo_frame: frames=%0d data=%h expected 1 frame a9a8a7a6a5a4a3a2a1a0", got_q.size(), data_out);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    for (int k = 0; k < 6; k++) begin
      send_byte(8'($urandom), 1'b1, CPB);
      tick(CPB);
    end
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(HALF);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== '0 || valid_out !== 1'b0 || busy_out !== 1'b0 || framing_err_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: data=%h valid=%b busy=%b ferr=%b expected all 0",
               data_out, valid_out, busy_out, framing_err_out);
    end
    tick(2);
    rst = 1'b0;
    model_bytes.delete();
    tick(2 * CPB);
    for (int k = 0; k < FB; k++) begin
      send_byte(8'($urandom), 1'b1, CPB);
      tick($urandom_range(0, CPB));
    end
    tick(5);
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0] || ferr_cnt != 0) begin
      errors++;
      $display("FAIL rst_recover: frames=%0d ferr=%0d data=%h expected 1 frame %h",
               got_q.size(), ferr_cnt, data_out, exp_q.size() > 0 ? exp_q[0] : '0);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    for (int k = 0; k < FB; k++) send_byte(8'($urandom), 1'b1, CPB + 1);
    for (int k = 0; k < FB; k++) send_byte(8'($urandom), 1'b1, CPB - 1);
    tick(10);
    checks++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: frames=%0d expected 2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ferr_cnt != 0 || wide_valid != 0 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_side: ferr=%0d wide=%0d busy=%b expected 0/0/0", ferr_cnt, wide_valid, busy_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_framing_error();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
